// File: rtl/st_pkg.sv
// Shared definitions for the 16-bit MIPS-style pipeline: opcodes, fetch-state
// encoding and the bubble instruction, used by stage 1, stage 2 and the hazard unit.
package st_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_HALT  = 4'b0000;
  localparam logic [3:0] OP_JUMP  = 4'b0001;
  localparam logic [3:0] OP_BGT   = 4'b0100;
  localparam logic [3:0] OP_BLT   = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_RTYPE = 4'b1111;

  localparam logic [INSTR_W-1:0] BUBBLE_INSTR = 16'h0000;
  localparam logic [ADDR_W-1:0]  PC_STEP      = 16'h0002;
  localparam logic [ADDR_W-1:0]  HALF_ALIGN   = 16'hFFFE;

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    HALT_SEEN = 2'b01,
    HALTED    = 2'b10
  } fetch_state_e;

  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[15:12];
  endfunction

endpackage

// File: rtl/st1_fetch_stage_if.sv
// Stage-1 bus bundle: instruction-memory port, hazard/redirect/halt controls
// and the IF/ID register outputs feeding stage 2.
interface st1_fetch_stage_if;
  import st_pkg::*;

  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               stall;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               halt_commit;
  logic [INSTR_W-1:0] if_id_instr;
  logic [ADDR_W-1:0]  if_id_pc2;
  logic               if_id_valid;
  logic               halted;

  modport master (
    output imem_addr, if_id_instr, if_id_pc2, if_id_valid, halted,
    input  imem_data, stall, redirect_valid, redirect_pc, halt_commit
  );

  modport slave (
    input  imem_addr, if_id_instr, if_id_pc2, if_id_valid, halted,
    output imem_data, stall, redirect_valid, redirect_pc, halt_commit
  );

endinterface

// File: rtl/st1_fetch_stage.sv
// Pipeline stage 1: program counter, instruction fetch and IF/ID register,
// with stall hold, redirect flush and the halt sequence.
module st1_fetch_stage
  import st_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input logic               clk,
  input logic               rst,
  st1_fetch_stage_if.master bus
);

  fetch_state_e       state_r, state_nxt_s;
  logic [ADDR_W-1:0]  pc_r, pc_nxt_s, pc_plus2_s;
  logic [INSTR_W-1:0] if_id_instr_r, instr_nxt_s;
  logic [ADDR_W-1:0]  if_id_pc2_r, pc2_nxt_s;
  logic               if_id_valid_r, valid_nxt_s;
  logic               halted_r;

  // 16-bit add wraps 16'hFFFE to 16'h0000 for both PC and link value
  assign pc_plus2_s = pc_r + PC_STEP;

  // Next-state / next-PC / IF/ID selection in priority order halt > redirect > stall > fetch
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    instr_nxt_s = if_id_instr_r;
    pc2_nxt_s   = if_id_pc2_r;
    valid_nxt_s = if_id_valid_r;
    if (bus.halt_commit) begin
      state_nxt_s = HALTED;
      valid_nxt_s = 1'b0;
    end else if (state_r == HALTED) begin
      state_nxt_s = HALTED;
    end else if (bus.redirect_valid) begin
      state_nxt_s = RUN;
      pc_nxt_s    = bus.redirect_pc & HALF_ALIGN;
      instr_nxt_s = BUBBLE_INSTR;
      valid_nxt_s = 1'b0;
    end else if (bus.stall) begin
      state_nxt_s = state_r;
    end else begin
      case (state_r)
        RUN: begin
          instr_nxt_s = bus.imem_data;
          pc2_nxt_s   = pc_plus2_s;
          valid_nxt_s = 1'b1;
          // A fetched halt is passed on once; the PC then parks on it
          if (opcode_of(bus.imem_data) == OP_HALT) begin
            state_nxt_s = HALT_SEEN;
          end else begin
            pc_nxt_s = pc_plus2_s;
          end
        end
        HALT_SEEN: begin
          instr_nxt_s = BUBBLE_INSTR;
          valid_nxt_s = 1'b0;
        end
        default: begin
          state_nxt_s = state_r;
        end
      endcase
    end
  end

  // State, PC and IF/ID registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= RUN;
      pc_r          <= RESET_PC;
      if_id_instr_r <= BUBBLE_INSTR;
      if_id_pc2_r   <= 16'h0000;
      if_id_valid_r <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      pc_r          <= pc_nxt_s;
      if_id_instr_r <= instr_nxt_s;
      if_id_pc2_r   <= pc2_nxt_s;
      if_id_valid_r <= valid_nxt_s;
      halted_r      <= (state_nxt_s == HALTED);
    end
  end

  assign bus.imem_addr   = pc_r;
  assign bus.if_id_instr = if_id_instr_r;
  assign bus.if_id_pc2   = if_id_pc2_r;
  assign bus.if_id_valid = if_id_valid_r;
  assign bus.halted      = halted_r;

endmodule
